branch_resolve_unit: RTL and testbench

//  Resolution side of the gshare predictor. Holds in-flight fetch predictions in order and compares each

---
 rtl/bru_pkg.sv | 22 ++
 rtl/bru_pred_fifo.sv | 49 ++++
 rtl/branch_resolve_unit.sv | 136 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit and its prediction FIFO.
package bru_pkg;

  localparam int BRU_PC_W = 32;
  localparam logic [BRU_PC_W-1:0] PC_INC = 32'd4;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [BRU_PC_W-1:0] pc;
    logic                pred_taken;
    logic [BRU_PC_W-1:0] pred_target;
  } bru_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bru_state_e;

endpackage

// File: rtl/bru_pred_fifo.sv
// In-order store of in-flight predictions; clear wins over push/pop.
module bru_pred_fifo
  import bru_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  bru_entry_t               din,
  output bru_entry_t               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  bru_entry_t  r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = r_mem[r_rd_ptr[AW-1:0]];
  assign count = r_wr_ptr - r_rd_ptr;
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves in-flight gshare predictions against EX outcomes; drives predictor update and flush/redirect.
// Optional counters stat_branches/stat_mispredicts are built when BRU_STATS_EN is defined.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int IDX_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [PC_W-1:0]          enq_pc,
  input  logic                     enq_pred_taken,
  input  logic [PC_W-1:0]          enq_pred_target,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [PC_W-1:0]          res_target,
  input  logic                     res_is_jump,
  output logic                     upd_valid,
  output logic [IDX_W-1:0]         upd_addr,
  output logic                     upd_taken,
  output logic                     flush,
  output logic [PC_W-1:0]          redirect_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_underflow
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]              stat_branches,
  output logic [31:0]              stat_mispredicts
`endif
);

  bru_state_e r_state;
  bru_state_e w_state_nxt;

  bru_entry_t w_enq_entry;
  bru_entry_t w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_res_ok;
  logic       w_mispredict;
  logic       w_push;
  logic       w_pop;
  logic       w_clear;

  logic                r_upd_valid;
  logic [IDX_W-1:0]    r_upd_addr;
  logic                r_upd_taken;
  logic                r_flush;
  logic [PC_W-1:0]     r_redirect_pc;
  logic                r_err_underflow;

  assign w_enq_entry = '{pc: enq_pc, pred_taken: enq_pred_taken, pred_target: enq_pred_target};

  // A resolve only counts while running with something queued; anything else is an underflow.
  assign enq_ready    = !w_full && (r_state == RUN);
  assign w_res_ok     = res_valid && !w_empty && (r_state == RUN);
  assign w_mispredict = (w_head.pred_taken != res_taken) ||
                        (res_taken && (w_head.pred_target != res_target));
  assign w_clear      = w_res_ok && w_mispredict;
  assign w_pop        = w_res_ok && !w_mispredict;
  assign w_push       = enq_valid && enq_ready && !w_clear;

  bru_pred_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .clear (w_clear),
    .din   (w_enq_entry),
    .dout  (w_head),
    .count (count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = RUN;
    if (r_state == RUN && w_clear) w_state_nxt = FLUSH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_upd_valid     <= 1'b0;
      r_upd_addr      <= '0;
      r_upd_taken     <= 1'b0;
      r_flush         <= 1'b0;
      r_redirect_pc   <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      r_upd_valid <= w_res_ok && !res_is_jump;
      r_flush     <= w_clear;
      if (w_res_ok) begin
        r_upd_addr  <= w_head.pc[IDX_W-1:0];
        r_upd_taken <= res_taken;
      end
      if (w_clear) r_redirect_pc <= res_taken ? res_target : (w_head.pc + PC_INC);
      if (res_valid && !w_res_ok) r_err_underflow <= 1'b1;
    end
  end

  assign upd_valid     = r_upd_valid;
  assign upd_addr      = r_upd_addr;
  assign upd_taken     = r_upd_taken;
  assign flush         = r_flush;
  assign redirect_pc   = r_redirect_pc;
  assign err_underflow = r_err_underflow;

`ifdef BRU_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (w_res_ok && !res_is_jump) r_stat_branches    <= r_stat_branches + 32'd1;
      if (w_clear)                  r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized plus directed bench for branch_resolve_unit against a queue-based reference model.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_pc;
  logic        enq_pred_taken;
  logic [31:0] enq_pred_target;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_is_jump;
  logic        upd_valid;
  logic [7:0]  upd_addr;
  logic        upd_taken;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [2:0]  count;
  logic        err_underflow;
`ifdef BRU_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_resolve_unit #(.DEPTH(DEPTH), .PC_W(32), .IDX_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .enq_valid       (enq_valid),
    .enq_ready       (enq_ready),
    .enq_pc          (enq_pc),
    .enq_pred_taken  (enq_pred_taken),
    .enq_pred_target (enq_pred_target),
    .res_valid       (res_valid),
    .res_taken       (res_taken),
    .res_target      (res_target),
    .res_is_jump     (res_is_jump),
    .upd_valid       (upd_valid),
    .upd_addr        (upd_addr),
    .upd_taken       (upd_taken),
    .flush           (flush),
    .redirect_pc     (redirect_pc),
    .count           (count),
    .err_underflow   (err_underflow)
`ifdef BRU_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
  } ent_t;

  ent_t        q[$];
  bit          m_flush;
  bit          m_err;
  bit          e_uv;
  bit          e_ut;
  bit          e_fl;
  logic [7:0]  e_ua;
  logic [31:0] e_rd;
  int unsigned m_br;
  int unsigned m_mp;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    enq_valid = 0; enq_pc = '0; enq_pred_taken = 0; enq_pred_target = '0;
    res_valid = 0; res_taken = 0; res_target = '0; res_is_jump = 0;
  endtask

  task automatic model_reset();
    q.delete();
    m_flush = 0; m_err = 0; m_br = 0; m_mp = 0;
  endtask

  // Apply one cycle of inputs, predict the outcome, and check both sides of the edge.
  task automatic step(input bit ev, input logic [31:0] epc, input bit ept, input logic [31:0] etg,
                      input bit rv, input bit rt, input logic [31:0] rtg, input bit rj);
    bit   rdy;
    bit   mis;
    ent_t h;
    enq_valid = ev; enq_pc = epc; enq_pred_taken = ept; enq_pred_target = etg;
    res_valid = rv; res_taken = rt; res_target = rtg; res_is_jump = rj;
    #1;
    rdy = (q.size() < DEPTH) && !m_flush;
    chk("enq_ready", enq_ready, rdy);
    chk("count_pre", count, q.size());
    e_uv = 0; e_fl = 0; mis = 0;
    if (rv) begin
      if (q.size() == 0 || m_flush) begin
        m_err = 1;
      end else begin
        h    = q.pop_front();
        mis  = (h.pt != rt) || (rt && h.tgt != rtg);
        e_uv = !rj;
        e_ua = h.pc[7:0];
        e_ut = rt;
        if (!rj) m_br++;
        if (mis) begin
          e_fl = 1;
          e_rd = rt ? rtg : h.pc + 32'd4;
          q.delete();
          m_mp++;
        end
      end
    end
    if (ev && rdy && !mis) q.push_back('{pc: epc, pt: ept, tgt: etg});
    m_flush = mis;
    @(posedge clk); #1;
    chk("upd_valid", upd_valid, e_uv);
    if (e_uv) begin
      chk("upd_addr", upd_addr, e_ua);
      chk("upd_taken", upd_taken, e_ut);
    end
    chk("flush", flush, e_fl);
    if (e_fl) chk("redirect_pc", redirect_pc, e_rd);
    chk("err_underflow", err_underflow, m_err);
    chk("count_post", count, q.size());
`ifdef BRU_STATS_EN
    chk("stat_branches", stat_branches, m_br);
    chk("stat_mispredicts", stat_mispredicts, m_mp);
`endif
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    idle();
    #2 rst = 1;
    #1;
    model_reset();
    chk("rst_count", count, 0);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_upd_addr", upd_addr, 0);
    chk("rst_upd_taken", upd_taken, 0);
    chk("rst_flush", flush, 0);
    chk("rst_redirect", redirect_pc, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_enq_ready", enq_ready, 1);
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic step_idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ev, ept, rv, rt, rj;
    logic [31:0] epc, etg, rtg;
    ent_t        h;
    idle();
    rst = 1;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // 1: correct taken prediction
    step(1, 32'h100, 1, 32'h140, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h140, 0);
    step_idle();

    // 2: predicted NT, actually taken -> flush, one cycle without ready
    step(1, 32'h1A4, 0, 32'h0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h200, 0);
    step(1, 32'h300, 0, 0, 0, 0, 0, 0);
    step_idle();

    // 3: three queued, mispredict on oldest with a same-cycle enqueue
    step(1, 32'h400, 1, 32'h500, 0, 0, 0, 0);
    step(1, 32'h404, 0, 32'h0,   0, 0, 0, 0);
    step(1, 32'h408, 1, 32'h600, 0, 0, 0, 0);
    step(1, 32'h40C, 0, 32'h0,   1, 0, 32'h0, 0);
    step_idle();

    // 4: full queue; resolve + enqueue pops only, then head is the second entry
    for (int i = 0; i < DEPTH; i++) step(1, 32'h800 + 32'(i * 4), 0, 0, 0, 0, 0, 0);
    step(1, 32'h900, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 0, 0);

    // PC increment wraps at 2^32
    step(1, 32'hFFFF_FFFC, 1, 32'h40, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step_idle();

    // 6: jump with wrong target -> flush, no predictor update
    step(1, 32'h10, 1, 32'h80, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h90, 1);
    step_idle();

    // 5: underflow is sticky until reset
    step(0, 0, 0, 0, 1, 1, 32'h0, 0);
    step_idle();
    step(1, 32'h20, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    do_reset();

    // Random traffic, with a mid-run reset halfway
    for (int n = 0; n < 600; n++) begin
      ev  = ($urandom_range(0, 99) < 60);
      epc = $urandom & 32'hFFFF_FFFC;
      ept = 1'($urandom);
      etg = $urandom & 32'hFFFF_FFFC;
      rj  = ($urandom_range(0, 3) == 0);
      rt  = 0; rtg = '0;
      if (q.size() > 0 && !m_flush) begin
        rv = ($urandom_range(0, 99) < 45);
        h  = q[0];
        if ($urandom_range(0, 99) < 80) begin
          rt  = h.pt;
          rtg = h.pt ? h.tgt : ($urandom & 32'hFFFF_FFFC);
        end else begin
          rt  = 1'($urandom);
          rtg = ($urandom_range(0, 1) == 0) ? h.tgt : ($urandom & 32'hFFFF_FFFC);
        end
      end else begin
        rv = ($urandom_range(0, 99) < 3);
      end
      step(ev, epc, ept, etg, rv, rt, rtg, rj);
      if (n == 300) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
